// File: rtl/score_display_ctrl_pkg.sv
// Shared constants, FSM states and helpers for the HEX score display.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package score_display_ctrl_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Load/status/segment bundle between control logic and the display block.
interface score_display_ctrl_if #(
  parameter int BIN_W      = 20,
  parameter int NUM_DIGITS = 6
);
  logic [BIN_W-1:0]        value_i;
  logic                    load_i;
  logic                    blank_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    overflow_o;
  logic [7*NUM_DIGITS-1:0] hex_o;

  modport master (
    output value_i, load_i, blank_i,
    input  busy_o, done_o, overflow_o, hex_o
  );

  modport slave (
    input  value_i, load_i, blank_i,
    output busy_o, done_o, overflow_o, hex_o
  );
endinterface

// File: rtl/score_display_ctrl_bin2bcd.sv
// Iterative double-dabble core: one add-3/shift step per cycle.
module bin2bcd_dd #(
  parameter int BIN_W      = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_value,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);
  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]        r_bin;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [CW-1:0]           r_cnt;
  logic                    r_run;
  logic [4*NUM_DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_value;
      r_bcd <= '0;
      r_cnt <= CW'(BIN_W);
      r_run <= 1'b1;
    end else if (r_run) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_run <= 1'b0;
    end
  end

  // high in the cycle whose closing edge performs the final shift
  assign o_done = r_run && (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/segment.sv
// BCD digit to active-low 7-segment code; non-decimal codes go dark.
import score_display_ctrl_pkg::*;

module segment (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_OFF;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/score_display_ctrl.sv
// Load sequencing, pending slot, blanking and registered HEX outputs
// wrapped around the double-dabble core.
import score_display_ctrl_pkg::*;

module score_display_ctrl #(
  parameter int BIN_W      = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  score_display_ctrl_if.slave bus
);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  state_t                  r_state, w_next;
  logic                    r_pend;
  logic [BIN_W-1:0]        r_pend_val;
  logic                    r_ovf;
  logic [4*NUM_DIGITS-1:0] r_disp_bcd;
  logic                    r_disp_ovf;
  logic                    r_disp_vld;
  logic                    r_done;
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic                    w_start_req;
  logic                    w_core_start;
  logic                    w_core_done;
  logic [4*NUM_DIGITS-1:0] w_core_bcd;
  logic [BIN_W-1:0]        w_src_val;
  logic                    w_src_ovf;
  logic [NUM_DIGITS-1:0]   w_lead;
  logic [6:0]              w_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_hex_nxt;

  bin2bcd_dd #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_dd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_core_start),
    .i_value (w_src_val),
    .o_done  (w_core_done),
    .o_bcd   (w_core_bcd)
  );

  // a load arriving in COMMIT supersedes the held one
  assign w_src_val = bus.load_i ? bus.value_i : r_pend_val;
  assign w_src_ovf = 64'(w_src_val) >= LIMIT;

  always_comb begin
    w_next       = r_state;
    w_start_req  = 1'b0;
    w_core_start = 1'b0;
    unique case (r_state)
      ST_IDLE:    w_start_req = bus.load_i;
      ST_CONVERT: if (w_core_done) w_next = ST_COMMIT;
      ST_COMMIT: begin
        w_next      = ST_IDLE;
        w_start_req = bus.load_i | r_pend;
      end
      default:    w_next = ST_IDLE;
    endcase
    if (w_start_req) begin
      w_next       = w_src_ovf ? ST_COMMIT : ST_CONVERT;
      w_core_start = !w_src_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_ovf      <= 1'b0;
      r_disp_bcd <= '0;
      r_disp_ovf <= 1'b0;
      r_disp_vld <= 1'b0;
      r_done     <= 1'b0;
      r_hex      <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_COMMIT);
      r_hex   <= w_hex_nxt;
      if (w_start_req) r_ovf <= w_src_ovf;
      if (r_state == ST_COMMIT) begin
        r_disp_bcd <= r_ovf ? '0 : w_core_bcd;
        r_disp_ovf <= r_ovf;
        r_disp_vld <= 1'b1;
        r_pend     <= 1'b0;
      end else if (r_state != ST_IDLE && bus.load_i) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.value_i;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    segment u_seg (
      .i_digit (r_disp_bcd[4*k +: 4]),
      .o_seg   (w_seg[k])
    );
    assign w_lead[k] = |r_disp_bcd[4*NUM_DIGITS-1:4*k];
  end

  // stays dark until the first value has been committed
  always_comb begin
    w_hex_nxt = {NUM_DIGITS{SEG_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bus.blank_i || !r_disp_vld)
        w_hex_nxt[7*k +: 7] = SEG_OFF;
      else if (r_disp_ovf)
        w_hex_nxt[7*k +: 7] = SEG_DASH;
      else if (k == 0 || w_lead[k])
        w_hex_nxt[7*k +: 7] = w_seg[k];
    end
  end

  assign bus.busy_o     = (r_state != ST_IDLE) | r_pend;
  assign bus.done_o     = r_done;
  assign bus.overflow_o = r_disp_ovf;
  assign bus.hex_o      = r_hex;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed vector bench for score_display_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_score_display_ctrl;
  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [6:0] DSH = 7'h3F;
  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24;
  localparam logic [6:0] D3 = 7'h30, D4 = 7'h19, D5 = 7'h12;
  localparam logic [6:0] D6 = 7'h02, D7 = 7'h78, D8 = 7'h00;
  localparam logic [6:0] D9 = 7'h10;
  localparam logic [41:0] ALL_OFF = {OFF, OFF, OFF, OFF, OFF, OFF};

  typedef struct {
    logic [19:0] val;
    int          edges;
    logic        ovf;
    logic [41:0] hex;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  score_display_ctrl_if #(.BIN_W(20), .NUM_DIGITS(6)) bus ();

  score_display_ctrl #(.BIN_W(20), .NUM_DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_to_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done_o === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  vec_t        vt [7];
  int          e;
  int          dq [$];
  logic [41:0] hexlog [0:79];
  int          seen7;
  int          ndone;
  int          hex_lit;

  initial begin
    vt[0] = '{20'd0,       21, 1'b0, {OFF, OFF, OFF, OFF, OFF, D0}};
    vt[1] = '{20'd123456,  21, 1'b0, {D1, D2, D3, D4, D5, D6}};
    vt[2] = '{20'd1000000,  1, 1'b1, {DSH, DSH, DSH, DSH, DSH, DSH}};
    vt[3] = '{20'd5,       21, 1'b0, {OFF, OFF, OFF, OFF, OFF, D5}};
    vt[4] = '{20'd999999,  21, 1'b0, {D9, D9, D9, D9, D9, D9}};
    vt[5] = '{20'd1048575,  1, 1'b1, {DSH, DSH, DSH, DSH, DSH, DSH}};
    vt[6] = '{20'd10,      21, 1'b0, {OFF, OFF, OFF, OFF, D1, D0}};

    rst_n       = 1'b0;
    bus.value_i = '0;
    bus.load_i  = 1'b0;
    bus.blank_i = 1'b0;
    repeat (3) tick();
    check("rst_hex", 64'(bus.hex_o), 64'(ALL_OFF));
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_ovf", 64'(bus.overflow_o), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hex", 64'(bus.hex_o), 64'(ALL_OFF));

    for (int i = 0; i < 7; i++) begin
      bus.value_i = vt[i].val;
      bus.load_i  = 1'b1;
      tick();
      bus.load_i  = 1'b0;
      check($sformatf("v%0d_busy", i), 64'(bus.busy_o), 64'd1);
      run_to_done(e);
      check($sformatf("v%0d_edges", i), 64'(e), 64'(vt[i].edges));
      check($sformatf("v%0d_ovf", i), 64'(bus.overflow_o), 64'(vt[i].ovf));
      tick();
      check($sformatf("v%0d_hex", i), 64'(bus.hex_o), 64'(vt[i].hex));
      check($sformatf("v%0d_idle", i), 64'(bus.busy_o), 64'd0);
    end

    // back-to-back: 7 then 9 while busy, only 9 survives
    bus.value_i = 20'd42;
    bus.load_i  = 1'b1;
    tick();
    seen7 = 0;
    for (int t = 1; t < 80; t++) begin
      bus.load_i  = (t == 4) || (t == 9);
      bus.value_i = (t == 4) ? 20'd7 : 20'd9;
      tick();
      hexlog[t] = bus.hex_o;
      if (bus.done_o === 1'b1) dq.push_back(t);
      if (bus.hex_o == {OFF, OFF, OFF, OFF, OFF, D7}) seen7++;
    end
    bus.load_i = 1'b0;
    check("b2b_npulse", 64'(dq.size()), 64'd2);
    check("b2b_done1", 64'(dq.size() > 0 ? dq[0] : -1), 64'd21);
    check("b2b_done2", 64'(dq.size() > 1 ? dq[1] : -1), 64'd42);
    check("b2b_hex42", 64'(hexlog[22]), 64'({OFF, OFF, OFF, OFF, D4, D2}));
    check("b2b_hex9", 64'(hexlog[43]), 64'({OFF, OFF, OFF, OFF, OFF, D9}));
    check("b2b_no7", 64'(seen7), 64'd0);

    // reset in the middle of a conversion
    bus.value_i = 20'd905;
    bus.load_i  = 1'b1;
    tick();
    bus.load_i  = 1'b0;
    ndone = 0;
    for (int t = 1; t < 10; t++) begin
      tick();
      if (bus.done_o === 1'b1) ndone++;
    end
    rst_n = 1'b0;
    tick();
    check("mrst_hex", 64'(bus.hex_o), 64'(ALL_OFF));
    check("mrst_busy", 64'(bus.busy_o), 64'd0);
    check("mrst_done", 64'(bus.done_o), 64'd0);
    check("mrst_ovf", 64'(bus.overflow_o), 64'd0);
    rst_n = 1'b1;
    hex_lit = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.done_o === 1'b1) ndone++;
      if (bus.hex_o !== ALL_OFF) hex_lit++;
    end
    check("mrst_nodone", 64'(ndone), 64'd0);
    check("mrst_dark", 64'(hex_lit), 64'd0);

    // blanking across a conversion of 88
    bus.blank_i = 1'b1;
    bus.value_i = 20'd88;
    bus.load_i  = 1'b1;
    tick();
    bus.load_i  = 1'b0;
    run_to_done(e);
    check("blk_edges", 64'(e), 64'd21);
    check("blk_hex_done", 64'(bus.hex_o), 64'(ALL_OFF));
    tick();
    check("blk_hex_held", 64'(bus.hex_o), 64'(ALL_OFF));
    bus.blank_i = 1'b0;
    tick();
    check("blk_hex_88", 64'(bus.hex_o), 64'({OFF, OFF, OFF, OFF, D8, D8}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequential front end for the active-low HEX digit decoders on the DE1-SoC board. It accepts a binary value, such as a game score or frame count, through a load pulse. It converts the value to BCD with a multi-cycle shift-add-3 (double-dabble) sequence, applies leading-zero blanking and overflow indication, and drives `NUM_DIGITS` registered 7-segment outputs. It sits between game/camera control logic and the HEX0..HEX5 pins. It also sequences reloads that arrive mid-conversion.

## Interface
- `BIN_W`, 20, width of binary input.
- `NUM_DIGITS`, 6, number of decimal digits driven. Legal range is 10^NUM_DIGITS-1 < 2^BIN_W.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset. Synchronous, active-low.
- `value_i`  in  BIN_W  binary value; sampled only when a load is accepted.
- `load_i`  in  1  request a display update with `value_i`.
- `blank_i`  in  1  force all digits dark.
- `busy_o`  out  1  conversion in progress or pending.
- `done_o`  out  1  one-cycle pulse when a new value is committed.
- `overflow_o`  out  1  last committed value ≥ 10^NUM_DIGITS.
- `hex_o`  out  7*NUM_DIGITS  segment codes, digit k at bits [7k+6:7k]. Segment order is g..a with bit 6 = g. A 0 bit lights a segment.

## Operation
- FSM states:
  - IDLE: waiting for a load.
  - CONVERT: double-dabble shifting.
  - COMMIT: latch the result.
- IDLE with `load_i`=1:
  - Capture `value_i` into the shift register.
  - Clear the BCD register (4*NUM_DIGITS bits).
  - If value ≥ 10^NUM_DIGITS, set the overflow flag and go to COMMIT.
  - Otherwise load counter = BIN_W and go to CONVERT.
- CONVERT, once per cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1 and decrement the counter.
  - After BIN_W shifts, go to COMMIT.
- COMMIT:
  - Copy the BCD result and overflow flag into the display register.
  - Pulse `done_o`.
  - If a load is pending, start it immediately (same rules as IDLE). Otherwise go to IDLE.
- Pending load:
  - Any `load_i`=1 while not IDLE sets a pending flag and overwrites the pending value. Latest wins; intermediate loads are dropped.
  - A single pending slot exists.
- `hex_o` register update, every cycle, in priority order:
  - If `blank_i`, drive all digits 7'h7F.
  - Else if overflow, drive every digit 7'b0111111 (dash).
  - Else decode each digit. Digits above the most significant nonzero digit are 7'h7F. Digit 0 is always shown.
- Digit codes 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- `busy_o` = (state ≠ IDLE) | pending.

## Timing
- Reset values: `hex_o` all 7'h7F, `busy_o`=0, `done_o`=0, `overflow_o`=0. Display register is cleared. Pending flag is cleared. State is IDLE.
- Normal load, with load sampled at edge E0:
  - `busy_o`=1 after E0.
  - Shifts occur at E1..E(BIN_W).
  - COMMIT at E(BIN_W+1): `done_o` high for the following cycle, `overflow_o` updated.
  - `hex_o` shows the new value after E(BIN_W+2).
  - Default latency: load→done 21 edges, load→hex 22 edges.
- Overflow load: `done_o` after E1, `hex_o` dashes after E2.
- Back-to-back loads: a pending load issues from COMMIT with no IDLE cycle. `done_o` pulses are separated by BIN_W+1 cycles.
- Simultaneous events:
  - `load_i` during the COMMIT cycle is treated as pending.
  - `blank_i` takes effect one cycle after it is sampled and does not disturb conversion.
- Reset mid-conversion: the in-flight and pending values are discarded, no `done_o` pulse is issued, and outputs go to their reset values at the reset edge.

## Structure
- Shared package holds:
  - 7-bit segment constants: digits 0–9, `SEG_OFF`=7'h7F, `SEG_DASH`=7'b0111111.
  - FSM state enum.
  - A function computing 10^N for the overflow compare.
- One sub-module, `bin2bcd_dd`: an iterative double-dabble core with start/done handshake, parameterized by BIN_W and NUM_DIGITS.
- Per-digit decoding reuses the team's existing `segment` decoder, NUM_DIGITS instances.
- Blanking, pending slot and output register live in the top level.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `hex_o` all 7'h7F, `busy_o`=0, `done_o`=0.
- Load 0 → `done_o` at edge 21, then digit0=1000000 and digits 1–5=7'h7F.
- Load 123456 → after 22 edges, digit5..digit0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, with `overflow_o`=0.
- Load 1000000 → `overflow_o`=1 and `done_o` at edge 1, then all six digits 0111111. A following load of 5 → digit0=0010010 and `overflow_o`=0.
- Load 42, then loads of 7 and 9 during busy → first commit shows digit1=0011001, digit0=0100100. Second commit follows 21 cycles later showing 9 (0010000). Exactly two `done_o` pulses occur; 7 is never displayed.
- Load 905, then `rst_n`=0 at edge 10 → no `done_o`, outputs at reset values. Afterwards `blank_i`=1 during a conversion of 88 → digits dark, `done_o` still pulses. Releasing `blank_i` shows 88 (0000000, 0000000) one cycle later.
